// File: rtl/fle_cfg_pkg.sv
// Shared types and sizing constants for the FLE configuration bl/wl loader.
package fle_cfg_pkg;

    localparam int NBITS   = 70;
    localparam int DW      = 8;
    localparam int GROUP   = 10;
    localparam int NWORDS  = (NBITS + DW - 1) / DW;
    localparam int NGROUPS = (NBITS + GROUP - 1) / GROUP;

    // Counter width that stays at least one bit wide for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int WCNT_W = cnt_w(NWORDS);
    localparam int GCNT_W = cnt_w(NGROUPS);
    localparam int TMR_W  = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        PULSE = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/fle_cfg_bl_wl_loader_if.sv
// Configuration word-stream and status bundle between a config master and the loader.
interface fle_cfg_bl_wl_loader_if #(
    parameter int DW = fle_cfg_pkg::DW
);
    logic          cfg_start;
    logic          cfg_abort;
    logic [DW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_busy;
    logic          cfg_done;

    modport master (
        output cfg_start, cfg_abort, cfg_data, cfg_valid,
        input  cfg_ready, cfg_busy, cfg_done
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_data, cfg_valid,
        output cfg_ready, cfg_busy, cfg_done
    );
endinterface

// File: rtl/fle_cfg_phase_timer.sv
// Loadable down-counter with zero flag, timing the SETUP/PULSE/HOLD phases.
module fle_cfg_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fle_cfg_bl_wl_loader.sv
// Assembles a config word stream into a shadow register and programs the FLE cell in timed wl groups.
module fle_cfg_bl_wl_loader
    import fle_cfg_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                     prog_clk,
    input  logic                     global_resetn,
    fle_cfg_bl_wl_loader_if.slave    cfg,
    output logic [0:NBITS-1]         bl,
    output logic [0:NBITS-1]         wl
);

    localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(NWORDS - 1);
    localparam logic [GCNT_W-1:0] LAST_GROUP = GCNT_W'(NGROUPS - 1);

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
    logic [0:NBITS-1]    shadow_q, shadow_d;
    logic [0:NBITS-1]    wl_q, wl_d;
    logic                ready_q, busy_q, done_q;

    logic                tmr_load;
    logic [TMR_W-1:0]    tmr_val;
    logic                tmr_zero;

    fle_cfg_phase_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (prog_clk),
        .rst_n      (global_resetn),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        gcnt_d   = gcnt_q;
        shadow_d = shadow_q;
        if ((state_q != IDLE) && cfg.cfg_abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg.cfg_start) begin
                        state_d = LOAD;
                        wcnt_d  = '0;
                    end
                end
                LOAD: begin
                    if (cfg.cfg_valid && ready_q) begin
                        // Cells past NBITS in the final word have no slot and fall away here.
                        for (int i = 0; i < NBITS; i++) begin
                            if (int'(wcnt_q) == (i / DW)) begin
                                shadow_d[i] = cfg.cfg_data[i % DW];
                            end
                        end
                        if (wcnt_q == LAST_WORD) begin
                            state_d = SETUP;
                            gcnt_d  = '0;
                        end else begin
                            wcnt_d = wcnt_q + 1'b1;
                        end
                    end
                end
                SETUP: if (tmr_zero) state_d = PULSE;
                PULSE: if (tmr_zero) state_d = HOLD;
                HOLD: begin
                    if (tmr_zero) begin
                        if (gcnt_q == LAST_GROUP) begin
                            state_d = DONE;
                        end else begin
                            gcnt_d  = gcnt_q + 1'b1;
                            state_d = SETUP;
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Every phase entry is a state change, so a change reloads the timer with that phase's length.
    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        case (state_d)
            SETUP:   tmr_val = TMR_W'(SETUP_CYC - 1);
            PULSE:   tmr_val = TMR_W'(PULSE_CYC - 1);
            HOLD:    tmr_val = TMR_W'(HOLD_CYC - 1);
            default: tmr_val = '0;
        endcase
    end

    // Outputs are decoded from the next state so the registered values track the live state.
    always_comb begin
        wl_d = '0;
        for (int i = 0; i < NBITS; i++) begin
            wl_d[i] = (state_d == PULSE) && (int'(gcnt_d) == (i / GROUP));
        end
    end

    always_ff @(posedge prog_clk or negedge global_resetn) begin
        if (!global_resetn) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            gcnt_q   <= '0;
            shadow_q <= '0;
            wl_q     <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            gcnt_q   <= gcnt_d;
            shadow_q <= shadow_d;
            wl_q     <= wl_d;
            ready_q  <= (state_d == LOAD);
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_d == DONE);
        end
    end

    assign bl            = shadow_q;
    assign wl            = wl_q;
    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_busy  = busy_q;
    assign cfg.cfg_done  = done_q;

endmodule
